// File: rtl/dcache_line_mover.sv
// rtl/dcache_line_mover.sv - data-cache line mover: optional victim write-back, then line fill
module dcache_line_mover #(
    parameter int dw = 32,
    parameter int iw = 7,
    parameter int ow = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [iw-1:0] req_index,
    input  logic [1:0]    req_way,
    input  logic          req_dirty,
    input  logic [31:0]   req_wb_addr,
    input  logic [31:0]   req_fill_addr,
    output logic          done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [iw-1:0] ram_index,
    output logic [1:0]    ram_way,
    output logic [ow-1:0] ram_offset,
    output logic [dw-1:0] ram_din,
    input  logic [dw-1:0] ram_dout0,
    input  logic [dw-1:0] ram_dout1,
    input  logic [dw-1:0] ram_dout2,
    input  logic [dw-1:0] ram_dout3,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [dw-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [dw-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WB_RD    = 3'd1;
    localparam logic [2:0] S_WB_REQ   = 3'd2;
    localparam logic [2:0] S_FILL_REQ = 3'd3;
    localparam logic [2:0] S_FILL_WR  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam int hw = 32 - ow - 2;
    localparam logic [ow-1:0] cnt_last = '1;

    logic [2:0]    state;
    logic [ow-1:0] cnt;
    logic [iw-1:0] index_r;
    logic [1:0]    way_r;
    logic [hw-1:0] wb_hi;
    logic [hw-1:0] fill_hi;
    logic [dw-1:0] data_r;
    logic [dw-1:0] rd_word;

    // Only the line-aligned part of each base is kept; word offset comes from cnt.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_wb_addr[ow+1:0], req_fill_addr[ow+1:0]};

    always_comb begin
        rd_word = ram_dout0;
        case (way_r)
            2'd1:    rd_word = ram_dout1;
            2'd2:    rd_word = ram_dout2;
            2'd3:    rd_word = ram_dout3;
            default: rd_word = ram_dout0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            index_r <= '0;
            way_r   <= '0;
            wb_hi   <= '0;
            fill_hi <= '0;
            data_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        index_r <= req_index;
                        way_r   <= req_way;
                        wb_hi   <= req_wb_addr[31:ow+2];
                        fill_hi <= req_fill_addr[31:ow+2];
                        cnt     <= '0;
                        state   <= req_dirty ? S_WB_RD : S_FILL_REQ;
                    end
                end
                S_WB_RD: begin
                    data_r <= rd_word;
                    state  <= S_WB_REQ;
                end
                S_WB_REQ: begin
                    if (mem_ack) begin
                        cnt   <= cnt + ow'(1);
                        state <= (cnt == cnt_last) ? S_FILL_REQ : S_WB_RD;
                    end
                end
                S_FILL_REQ: begin
                    if (mem_ack) begin
                        data_r <= mem_rdata;
                        state  <= S_FILL_WR;
                    end
                end
                S_FILL_WR: begin
                    cnt   <= cnt + ow'(1);
                    state <= (cnt == cnt_last) ? S_DONE : S_FILL_REQ;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        done      = (state == S_DONE);
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        case (state)
            S_WB_RD: ram_en = 1'b1;
            S_WB_REQ: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {wb_hi, cnt, 2'b00};
            end
            S_FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {fill_hi, cnt, 2'b00};
            end
            S_FILL_WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign ram_index  = (state == S_IDLE) ? '0 : index_r;
    assign ram_way    = way_r;
    assign ram_offset = cnt;
    assign ram_din    = data_r;
    assign mem_wdata  = data_r;

endmodule

// File: tb/tb_dcache_line_mover.sv
// tb/tb_dcache_line_mover.sv - scoreboard bench for dcache_line_mover
module tb_dcache_line_mover;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_index = '0;
    logic [1:0]  req_way = '0;
    logic        req_dirty = 1'b0;
    logic [31:0] req_wb_addr = '0;
    logic [31:0] req_fill_addr = '0;
    logic        done;
    logic        ram_en, ram_we;
    logic [6:0]  ram_index;
    logic [1:0]  ram_way;
    logic [1:0]  ram_offset;
    logic [31:0] ram_din;
    logic [31:0] ram_dout0, ram_dout1, ram_dout2, ram_dout3;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_done = 0;
    logic        ack_high = 1'b1;
    logic        use_delay = 1'b0;
    int          wcnt = 0;
    logic [31:0] rd_base = '0;
    logic        hold_prev = 1'b0;
    logic [64:0] prev_mem = '0;

    always #5 clk = ~clk;

    dcache_line_mover #(.dw(32), .iw(7), .ow(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_way(req_way), .req_dirty(req_dirty), .req_wb_addr(req_wb_addr),
        .req_fill_addr(req_fill_addr), .done(done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_index(ram_index), .ram_way(ram_way),
        .ram_offset(ram_offset), .ram_din(ram_din),
        .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2), .ram_dout3(ram_dout3),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] dout_val(int w, logic [1:0] k);
        case (w)
            0:       return 32'h10 + 32'(k);
            1:       return 32'h20 + 32'(k);
            2:       return 32'hB0 + 32'(k);
            default: return 32'h30 + 32'(k);
        endcase
    endfunction

    function automatic logic [31:0] rcode(logic [6:0] i, logic [1:0] w, logic [1:0] o);
        return {9'b0, i, 6'b0, w, 6'b0, o};
    endfunction

    // Data-RAM and memory models
    assign ram_dout0 = dout_val(0, ram_offset);
    assign ram_dout1 = dout_val(1, ram_offset);
    assign ram_dout2 = dout_val(2, ram_offset);
    assign ram_dout3 = dout_val(3, ram_offset);
    assign mem_rdata = rd_base + 32'(mem_addr[3:2]);
    assign mem_ack   = ack_high | (use_delay & mem_req & (wcnt == 3));

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic check(string tag, logic [95:0] obs, logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe(ev_t ev);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_extra_event", 96'(exp_q.size()), 96'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_event", 96'(ev), 96'(e));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (mem_req && mem_ack)
                observe({mem_we ? 2'd0 : 2'd1, mem_addr, mem_we ? mem_wdata : 32'h0});
            if (ram_en && ram_we)
                observe({2'd2, rcode(ram_index, ram_way, ram_offset), ram_din});
            if (done) n_done++;
            if (mem_req && hold_prev)
                check("mem_hold", 96'({mem_we, mem_addr, mem_wdata}), 96'(prev_mem));
            hold_prev = mem_req && !mem_ack;
            prev_mem  = {mem_we, mem_addr, mem_wdata};
        end
    end

    task automatic push_line(logic dirty, logic [1:0] w, logic [6:0] idx,
                             logic [31:0] wb, logic [31:0] fill, logic [31:0] rdb, int nwords);
        for (int k = 0; k < 4; k++)
            if (dirty) exp_q.push_back({2'd0, wb[31:4], 2'(k), 2'b00, dout_val(int'(w), 2'(k))});
        for (int k = 0; k < nwords; k++) begin
            exp_q.push_back({2'd1, fill[31:4], 2'(k), 2'b00, 32'h0});
            exp_q.push_back({2'd2, rcode(idx, w, 2'(k)), rdb + 32'(k)});
        end
    endtask

    task automatic start_req(logic [6:0] idx, logic [1:0] w, logic dirty,
                             logic [31:0] wb, logic [31:0] fill);
        @(posedge clk); #1;
        check("ready_before_req", 96'(req_ready), 96'd1);
        req_index = idx; req_way = w; req_dirty = dirty;
        req_wb_addr = wb; req_fill_addr = fill; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(string tag, int exp_lat, logic poke);
        int cyc;
        cyc = 1;
        while (!done && cyc < 400) begin
            if (poke && cyc == 3) begin
                req_index = 7'h55; req_way = 2'd0; req_dirty = 1'b1;
                req_wb_addr = 32'h9000; req_fill_addr = 32'hA000; req_valid = 1'b1;
            end
            if (poke && cyc == 4) req_valid = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b0;
        check(tag, 96'(cyc), 96'(exp_lat));
        @(posedge clk); #1;
        check("done_one_cycle", 96'(done), 96'd0);
        check("ready_after_done", 96'(req_ready), 96'd1);
        check("sb_drained", 96'(exp_q.size()), 96'd0);
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 96'(req_ready), 96'd1);
        check("rst_done", 96'(done), 96'd0);
        check("rst_ram_en", 96'(ram_en), 96'd0);
        check("rst_ram_we", 96'(ram_we), 96'd0);
        check("rst_mem_req", 96'(mem_req), 96'd0);
        check("rst_mem_we", 96'(mem_we), 96'd0);
        check("rst_mem_addr", 96'(mem_addr), 96'd0);
        check("rst_mem_wdata", 96'(mem_wdata), 96'd0);
        check("rst_ram_din", 96'(ram_din), 96'd0);
        check("rst_ram_index", 96'(ram_index), 96'd0);
        check("rst_ram_way", 96'(ram_way), 96'd0);
        check("rst_ram_offset", 96'(ram_offset), 96'd0);
        rst = 1'b0;

        // clean miss, zero-wait memory
        rd_base = 32'hA0;
        push_line(1'b0, 2'd1, 7'h05, 32'h0, 32'h1000, rd_base, 4);
        start_req(7'h05, 2'd1, 1'b0, 32'h0, 32'h1000);
        wait_done("lat_clean", 9, 1'b0);

        // dirty miss, way 2
        rd_base = 32'hE0;
        push_line(1'b1, 2'd2, 7'h7F, 32'h2000, 32'h3000, rd_base, 4);
        start_req(7'h7F, 2'd2, 1'b1, 32'h2000, 32'h3000);
        wait_done("lat_dirty", 17, 1'b0);

        // dirty miss with 3-cycle memory latency, unaligned bases
        ack_high = 1'b0; use_delay = 1'b1; rd_base = 32'h40;
        push_line(1'b1, 2'd0, 7'h11, 32'h4008, 32'h5004, rd_base, 4);
        start_req(7'h11, 2'd0, 1'b1, 32'h4008, 32'h5004);
        wait_done("lat_delayed", 41, 1'b0);

        // request pulsed while busy must be ignored
        ack_high = 1'b1; use_delay = 1'b0; rd_base = 32'h55;
        d0 = n_done;
        push_line(1'b0, 2'd3, 7'h2A, 32'h0, 32'h6000, rd_base, 4);
        start_req(7'h2A, 2'd3, 1'b0, 32'h0, 32'h6000);
        wait_done("lat_poke", 9, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("poke_one_done", 96'(n_done - d0), 96'd1);
        check("poke_idle", 96'(req_ready), 96'd1);

        // reset while waiting in the third fill request
        ack_high = 1'b0; use_delay = 1'b1; rd_base = 32'h70;
        push_line(1'b0, 2'd1, 7'h03, 32'h0, 32'h7000, rd_base, 2);
        start_req(7'h03, 2'd1, 1'b0, 32'h0, 32'h7000);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ready", 96'(req_ready), 96'd1);
        check("abort_mem_req", 96'(mem_req), 96'd0);
        check("abort_ram_en", 96'(ram_en), 96'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_sb_drained", 96'(exp_q.size()), 96'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_mem_req", 96'(mem_req), 96'd0);

        // restart at offset 0 with an unaligned fill base
        ack_high = 1'b1; use_delay = 1'b0; rd_base = 32'hD0;
        push_line(1'b0, 2'd1, 7'h03, 32'h0, 32'h100F, rd_base, 4);
        start_req(7'h03, 2'd1, 1'b0, 32'h0, 32'h100F);
        wait_done("lat_restart", 9, 1'b0);

        check("total_done", 96'(n_done), 96'd5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_line_mover.md
DCACHE_LINE_MOVER -- requirements
Module: dcache_line_mover

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- dw, 32, data word width.
- iw, 7, set-index width.
- ow, 2, word-offset width; the line holds 2^ow words.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Ports, one per line: name  direction  width  meaning.
- clk  in  1  clock, all state changes on posedge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  line-miss request.
- req_ready  out  1  block idle; a request is accepted when req_valid & req_ready.
- req_index  in  iw  set index of the line.
- req_way  in  2  victim/fill way.
- req_dirty  in  1  victim must be written back first.
- req_wb_addr  in  32  victim line base byte address.
- req_fill_addr  in  32  miss line base byte address.
- done  out  1  one-cycle pulse: line move complete.
- ram_en, ram_we  out  1 each  data-RAM enable and write strobe.
- ram_index  out  iw  data-RAM index.
- ram_way  out  2  data-RAM write way.
- ram_offset  out  ow  data-RAM word offset.
- ram_din  out  dw  data-RAM write data.
- ram_dout0..ram_dout3  in  dw each  combinational per-way data-RAM read data.
- mem_req, mem_we  out  1 each  memory request and write flag.
- mem_addr  out  32  memory word byte address.
- mem_wdata  out  dw  memory write data.
- mem_ack  in  1  one-cycle completion of the current memory request.
- mem_rdata  in  dw  read data, valid with mem_ack.

Function
REQ-004 States: IDLE, WB_RD, WB_REQ, FILL_REQ, FILL_WR, DONE; a word counter cnt (ow bits); request fields registered on acceptance.
REQ-005 IDLE: req_ready=1; on acceptance, cnt<=0 and go to WB_RD if req_dirty, else FILL_REQ.
REQ-006 WB_RD (1 cycle): ram_en=1, ram_we=0, ram_offset=cnt; capture ram_dout[way] into the write-data register; go to WB_REQ.
REQ-007 WB_REQ: mem_req=1, mem_we=1, mem_addr=wb_base with bits [ow+1:0] replaced by {cnt,2'b00}, mem_wdata=captured word; hold all until mem_ack.
- On ack: cnt+1.
- If cnt was 2^ow-1, cnt wraps to 0 and the state goes to FILL_REQ; else it goes to WB_RD.
REQ-008 FILL_REQ: mem_req=1, mem_we=0, mem_addr formed from fill_base as in REQ-007; on mem_ack capture mem_rdata and go to FILL_WR.
REQ-009 FILL_WR (1 cycle): ram_en=1, ram_we=1, ram_way=registered way, ram_offset=cnt, ram_din=captured word; cnt+1.
- If cnt was 2^ow-1, go to DONE; else go to FILL_REQ.
REQ-010 DONE: done=1 for exactly one cycle, then IDLE; req_ready=0 in DONE.
REQ-011 ram_index SHALL equal the registered index in every non-IDLE state.
REQ-012 ram_en, ram_we, mem_req and done SHALL be 0 in every state not listed for them above.
REQ-013 mem_ack SHALL be honoured in the same cycle mem_req is first asserted (zero wait); mem_ack outside WB_REQ/FILL_REQ SHALL be ignored.
REQ-014 mem_addr/mem_we/mem_wdata SHALL be stable while mem_req=1 and no ack has arrived.
REQ-015 req_valid while req_ready=0 SHALL be ignored (no queuing).
REQ-016 The low 2 bits of the base addresses SHALL be ignored, and bits [ow+1:2] SHALL come only from cnt.

Reset
REQ-017 rst SHALL force IDLE, cnt=0, all registers 0, req_ready=1, and done, ram_en, ram_we, mem_req, mem_we=0; mem_addr, mem_wdata, ram_din, ram_index, ram_way, ram_offset=0.
REQ-018 rst mid-operation SHALL abort immediately, with no further RAM write or memory request until a new request is accepted.

Verification
REQ-019 Clean miss, ow=2, mem_ack tied high, req_fill_addr=0x1000, mem_rdata=0xA0..0xA3 -> fill addresses 0x1000, 0x1004, 0x1008, 0x100C; RAM writes at offsets 0..3 with the data in order; done pulses in the 9th cycle after acceptance.
REQ-020 Dirty miss, way=2, ram_dout2=0xB0..0xB3 by offset, req_wb_addr=0x2000, ack tied high -> 4 writes to 0x2000..0x200C with data 0xB0..0xB3, then the fill; done in the 17th cycle after acceptance.
REQ-021 mem_ack delayed 3 cycles per request -> mem_req and all address/data outputs held stable for 3 cycles, with no RAM write until the ack.
REQ-022 req_valid pulsed during a fill -> ignored; exactly one done pulse.
REQ-023 rst asserted in FILL_REQ after 2 words -> next cycle IDLE, req_ready=1, mem_req=0; a new request restarts at offset 0.
REQ-024 req_fill_addr=0x100F -> first fill address 0x1000.
